// File: rtl/ring_phase_decoder.sv
// ring_phase_decoder
//   Consumer of a WIDTH-bit one-hot ring counter that rotates right
//   (0001 -> 1000 -> 0100 -> 0010 -> 0001). Each sample must be one-hot and
//   must be the next rotation step. The module reports a registered binary
//   phase index, lock/fault status, and a pulse for each completed revolution.
//
//   Optional feature macro: RING_REV_CNT_EN. When it is defined, the block adds
//   the rev_cnt output, which counts revolutions since lock.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous active-high reset
//   ring_in   in   WIDTH   ring counter sample
//   ring_vld  in   1       ring_in valid; one rotation step per valid cycle
//   clr_err   in   1       pulse that clears a sticky fault
//   idx       out  IW      bit position of the set bit in the last accepted sample
//   idx_vld   out  1       idx is meaningful (LOCKING or LOCKED)
//   locked    out  1       ring is tracked and stepping correctly
//   err       out  1       sticky fault
//   wrap      out  1       one-cycle pulse when a revolution completes
//   rev_cnt   out  REV_W   revolutions since lock (RING_REV_CNT_EN only)
module ring_phase_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8,
  localparam int IW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_vld,
  input  logic             clr_err,
  output logic [IW-1:0]    idx,
  output logic             idx_vld,
  output logic             locked,
  output logic             err,
  output logic             wrap
`ifdef RING_REV_CNT_EN
  ,
  output logic [REV_W-1:0] rev_cnt
`endif
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);

  generate
    if (WIDTH < 2 || LOCK_CNT < 1 || REV_W < 1) begin : g_bad_param
      $error("ring_phase_decoder: illegal parameter value");
    end
  endgenerate

  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED, FAULT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] prev;
  logic [IW-1:0]    enc;
  logic             legal, good;
  logic             idx_load, wrap_nxt, lock_entry;

  // A value is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
  assign legal = (ring_in != '0) && ((ring_in & (ring_in - 1'b1)) == '0);
  assign good  = legal && (ring_in == {prev[0], prev[WIDTH-1:1]});

  // Report the highest set bit. For a legal sample, that is the only set bit.
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) enc = IW'(i);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default here. A path that skips an assignment
    // would otherwise infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_load   = 1'b0;
    wrap_nxt   = 1'b0;
    lock_entry = 1'b0;
    unique case (state)
      HUNT: begin
        if (ring_vld && legal) begin
          state_nxt = LOCKING;
          cnt_nxt   = '0;
          idx_load  = 1'b1;
        end
      end
      LOCKING: begin
        if (ring_vld) begin
          if (good) begin
            idx_load = 1'b1;
            if (cnt + CW'(1) == CW'(LOCK_CNT)) begin
              state_nxt  = LOCKED;
              cnt_nxt    = '0;
              lock_entry = 1'b1;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else if (legal) begin
            // A legal sample on the wrong step re-anchors the step count.
            cnt_nxt  = '0;
            idx_load = 1'b1;
          end else begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
          end
        end
      end
      LOCKED: begin
        if (ring_vld) begin
          if (good) begin
            idx_load = 1'b1;
            wrap_nxt = (ring_in == TOP_BIT);
          end else begin
            // A fault takes priority over a clr_err arriving in the same cycle.
            state_nxt = FAULT;
          end
        end
      end
      FAULT: begin
        if (clr_err) begin
          state_nxt = HUNT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then sample pre-edge values, and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every register here is a real flop with an async reset. There is no
  // memory array, so nothing relies on an unreset power-up value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      idx     <= '0;
      idx_vld <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      if (ring_vld && state != FAULT) prev <= ring_in;
      if (idx_load) idx <= enc;
      idx_vld <= (state_nxt == LOCKING) || (state_nxt == LOCKED);
      locked  <= (state_nxt == LOCKED);
      err     <= (state_nxt == FAULT);
      wrap    <= wrap_nxt;
    end
  end

`ifdef RING_REV_CNT_EN
  // Clear on lock entry. Increment in step with the wrap pulse, so rev_cnt
  // reflects the new count in the same cycle that wrap is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_cnt <= '0;
    end else if (lock_entry) begin
      rev_cnt <= '0;
    end else if (wrap_nxt) begin
      rev_cnt <= rev_cnt + 1'b1;
    end
  end
`else
  logic unused_lock_entry;
  assign unused_lock_entry = lock_entry;
`endif

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Self-checking bench for ring_phase_decoder (WIDTH=4, LOCK_CNT=2, REV_W=8).
// The bench has three parts:
//   - a directed vector table;
//   - an async-reset and rev_cnt modulo sequence;
//   - a randomized run compared against a positional reference model.
// The model tracks phase as an integer bit position. A step is correct when
// the position moves down by one, modulo WIDTH.
module tb_ring_phase_decoder;

  localparam int W  = 4;
  localparam int LC = 2;
  localparam int RW = 8;
  localparam int IW = 2;

  localparam int M_HUNT    = 0;
  localparam int M_LOCKING = 1;
  localparam int M_LOCKED  = 2;
  localparam int M_FAULT   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  ring_in;
  logic          ring_vld;
  logic          clr_err;
  logic [IW-1:0] idx;
  logic          idx_vld;
  logic          locked;
  logic          err;
  logic          wrap;
`ifdef RING_REV_CNT_EN
  logic [RW-1:0] rev_cnt;
`endif

  ring_phase_decoder #(.WIDTH(W), .LOCK_CNT(LC), .REV_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ring_in  (ring_in),
    .ring_vld (ring_vld),
    .clr_err  (clr_err),
    .idx      (idx),
    .idx_vld  (idx_vld),
    .locked   (locked),
    .err      (err),
    .wrap     (wrap)
`ifdef RING_REV_CNT_EN
    ,
    .rev_cnt  (rev_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_mode;
  int           m_steps;
  int           m_idx;
  bit           m_wrap;
  int           m_rev;
  logic [W-1:0] m_prev;

  function automatic int hi_pos(input logic [W-1:0] s);
    int p = -1;
    for (int i = 0; i < W; i++) if (s[i]) p = i;
    return p;
  endfunction

  task automatic model_reset();
    m_mode = M_HUNT; m_steps = 0; m_idx = 0; m_wrap = 0; m_rev = 0; m_prev = '0;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] s, input bit c);
    bit lg, gd;
    int p, pp;
    m_wrap = 0;
    lg = ($countones(s) == 1);
    p  = hi_pos(s);
    pp = ($countones(m_prev) == 1) ? hi_pos(m_prev) : -1;
    gd = lg && (pp >= 0) && (p == (pp + W - 1) % W);
    if (m_mode == M_FAULT) begin
      if (c) m_mode = M_HUNT;
      return;
    end
    if (!v) return;
    m_prev = s;
    case (m_mode)
      M_HUNT: if (lg) begin m_mode = M_LOCKING; m_steps = 0; m_idx = p; end
      M_LOCKING: begin
        if (gd) begin
          m_idx = p;
          m_steps++;
          if (m_steps >= LC) begin m_mode = M_LOCKED; m_rev = 0; end
        end else if (lg) begin
          m_steps = 0; m_idx = p;
        end else begin
          m_mode = M_HUNT;
        end
      end
      M_LOCKED: begin
        if (gd) begin
          m_idx = p;
          if (p == W - 1) begin m_wrap = 1; m_rev = (m_rev + 1) % (1 << RW); end
        end else begin
          m_mode = M_FAULT;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".idx"},     32'(idx),     32'(m_idx));
    check({tag, ".idx_vld"}, 32'(idx_vld), 32'(m_mode == M_LOCKING || m_mode == M_LOCKED));
    check({tag, ".locked"},  32'(locked),  32'(m_mode == M_LOCKED));
    check({tag, ".err"},     32'(err),     32'(m_mode == M_FAULT));
    check({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
`ifdef RING_REV_CNT_EN
    check({tag, ".rev_cnt"}, 32'(rev_cnt), 32'(m_rev));
`endif
  endtask

  // One clock: drive, advance the model, then sample 1 time unit after the edge.
  task automatic cycle(input bit v, input logic [W-1:0] s, input bit c, input string tag);
    ring_vld = v; ring_in = s; clr_err = c;
    @(posedge clk);
    model_step(v, s, c);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; ring_vld = 1'b0; ring_in = '0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit           v;
    logic [W-1:0] s;
    bit           c;
    int           e_idx;
    bit           e_ivld, e_lk, e_err, e_wrap;
    int           e_rev;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit v, input logic [W-1:0] s, input bit c, input int ei,
                              input bit ev, input bit el, input bit ee, input bit ew, input int er);
    vec_t t;
    t.v = v; t.s = s; t.c = c; t.e_idx = ei; t.e_ivld = ev; t.e_lk = el;
    t.e_err = ee; t.e_wrap = ew; t.e_rev = er;
    return t;
  endfunction

  initial begin
    int cur;
    // T1/T2: acquire lock, then a revolution ending on 1000 produces wrap.
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 3, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 3, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0010, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 3, 1, 1, 0, 0, 1));
    // T3: multi-hot sample while locked, then a fault-state sample is ignored, then clear.
    tbl.push_back(mk(1, 4'b0100, 0, 2, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0110, 0, 2, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 0, 2, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 2, 0, 0, 0, 0, 1));
    // T5: illegal samples in HUNT, then re-anchor in LOCKING.
    tbl.push_back(mk(1, 4'b0000, 0, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0011, 0, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0100, 0, 2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0010, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 0, 0, 0));
    // T4: skipped step from 1000.
    tbl.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0010, 0, 3, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 3, 0, 0, 0, 0, 1));
    // T4: stuck on 1000.
    tbl.push_back(mk(1, 4'b1000, 0, 3, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0100, 0, 2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0010, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 3, 1, 1, 0, 1, 1));
    tbl.push_back(mk(1, 4'b1000, 0, 3, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 3, 0, 0, 0, 0, 1));
    // T6: a fault coinciding with clr_err wins.
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b1000, 0, 3, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0100, 0, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 2, 0, 0, 0, 0, 0));
    // An illegal sample while LOCKING returns to HUNT.
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0101, 0, 0, 0, 0, 0, 0, 0));

    // Reset state.
    do_reset();
    check("reset.idx",     32'(idx),     32'd0);
    check("reset.idx_vld", 32'(idx_vld), 32'd0);
    check("reset.locked",  32'(locked),  32'd0);
    check("reset.err",     32'(err),     32'd0);
    check("reset.wrap",    32'(wrap),    32'd0);

    foreach (tbl[i]) begin
      ring_vld = tbl[i].v; ring_in = tbl[i].s; clr_err = tbl[i].c;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.idx", i),     32'(idx),     32'(tbl[i].e_idx));
      check($sformatf("vec%0d.idx_vld", i), 32'(idx_vld), 32'(tbl[i].e_ivld));
      check($sformatf("vec%0d.locked", i),  32'(locked),  32'(tbl[i].e_lk));
      check($sformatf("vec%0d.err", i),     32'(err),     32'(tbl[i].e_err));
      check($sformatf("vec%0d.wrap", i),    32'(wrap),    32'(tbl[i].e_wrap));
`ifdef RING_REV_CNT_EN
      check($sformatf("vec%0d.rev_cnt", i), 32'(rev_cnt), 32'(tbl[i].e_rev));
`endif
    end

    // T6: five revolutions while locked, then an async reset mid-cycle.
    do_reset();
    cur = 0;
    for (int n = 0; n < 3 + 4 * 5; n++) begin
      cycle(1'b1, W'(1) << cur, 1'b0, $sformatf("rev5.%0d", n));
      cur = (cur + W - 1) % W;
    end
`ifdef RING_REV_CNT_EN
    check("rev5.count", 32'(rev_cnt), 32'd5);
`endif
    check("rev5.locked", 32'(locked), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst.idx",     32'(idx),     32'd0);
    check("async_rst.idx_vld", 32'(idx_vld), 32'd0);
    check("async_rst.locked",  32'(locked),  32'd0);
    check("async_rst.err",     32'(err),     32'd0);
    check("async_rst.wrap",    32'(wrap),    32'd0);
`ifdef RING_REV_CNT_EN
    check("async_rst.rev_cnt", 32'(rev_cnt), 32'd0);
`endif
    do_reset();
    // After reset, the module must be back in HUNT. A lone 1000 only reaches LOCKING.
    cycle(1'b1, 4'b1000, 1'b0, "post_rst");

    // Long locked run to carry rev_cnt past 2^REV_W.
    do_reset();
    cur = 0;
    for (int n = 0; n < 3 + 4 * 260; n++) begin
      cycle(1'b1, W'(1) << cur, 1'b0, $sformatf("long.%0d", n));
      cur = (cur + W - 1) % W;
    end

    // Randomized traffic: mostly correct steps, plus gaps, stuck values,
    // random codes and clr_err pulses.
    do_reset();
    cur = 0;
    for (int n = 0; n < 3000; n++) begin
      bit           v, c;
      logic [W-1:0] s;
      int           k;
      v = ($urandom_range(99) >= 12);
      c = ($urandom_range(99) < 4);
      s = '0;
      if (v) begin
        k = $urandom_range(99);
        if (k < 4) begin
          s = W'($urandom);
          if ($countones(s) == 1) cur = hi_pos(s);
        end else if (k < 6) begin
          s = W'(1) << cur;
        end else begin
          cur = (cur + W - 1) % W;
          s = W'(1) << cur;
        end
      end
      cycle(v, s, c, $sformatf("rnd.%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
